// File: rtl/backprop_sequencer.sv
// ---------------------------------------------------------------------------
// backprop_sequencer
//
// Control sequencer for backprop_stack. A pass walks the layers from the last
// one down to layer 0. For every layer it first feeds `size` input rows, then
// it drains that layer's `size` weight-row updates before moving down a layer.
//
// Ports
//   clk                  rising-edge clock
//   rst_n                asynchronous active-low reset
//   start                pulse, begins a pass (only looked at in IDLE)
//   abort                synchronous abort, returns to IDLE next cycle
//   cfg_num_layers       layer count, latched when a start is accepted
//   row_valid            upstream row data valid for the current row
//   is_update_weight     one update row presented this cycle (DRAIN only)
//   row_ready            row consumed this cycle
//   current_input_layer  layer index being processed
//   current_input_row    row index within the layer, 0..size-1
//   is_last_layer        current layer is cfg_num_layers-1
//   start_new_layer      one-cycle pulse at the start of each layer
//   read_update_data     high throughout DRAIN
//   active_train         high in LAYER_START, ROW_FEED and DRAIN
//   busy                 high whenever the sequencer is not idle
//   done                 one-cycle pulse when a pass completes
//   err                  one-cycle pulse on a bad config or a drain timeout
// ---------------------------------------------------------------------------
module backprop_sequencer #(
  parameter int max_layer_size = 4,
  parameter int data_size      = 16,
  parameter int size           = 3,
  parameter int drain_timeout  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cfg_num_layers,
  input  logic        row_valid,
  input  logic        is_update_weight,
  output logic        row_ready,
  output logic [31:0] current_input_layer,
  output logic [31:0] current_input_row,
  output logic        is_last_layer,
  output logic        start_new_layer,
  output logic        read_update_data,
  output logic        active_train,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LAYER_START = 3'd1;
  localparam logic [2:0] S_ROW_FEED    = 3'd2;
  localparam logic [2:0] S_DRAIN       = 3'd3;
  localparam logic [2:0] S_DONE        = 3'd4;

  // Both drain counters share one width, wide enough for the larger limit.
  localparam int cnt_max = (size > drain_timeout) ? size : drain_timeout;
  localparam int cnt_w   = $clog2(cnt_max + 1);

  // A degenerate parameter set can never start a pass.
  localparam bit params_ok = (data_size > 0) && (size > 0) &&
                             (drain_timeout > 0) && (max_layer_size > 0);

  logic [2:0]       state, state_n;
  logic [31:0]      num_layers, num_layers_n;
  logic [31:0]      layer_n, row_n;
  logic [cnt_w-1:0] upd_cnt, upd_cnt_n;
  logic [cnt_w-1:0] idle_cnt, idle_cnt_n;
  logic [cnt_w-1:0] upd_inc, idle_inc;
  logic             err_n;
  logic             cfg_ok;
  logic             active_n;

  assign upd_inc  = upd_cnt + cnt_w'(1);
  assign idle_inc = idle_cnt + cnt_w'(1);

  assign cfg_ok = params_ok &&
                  (cfg_num_layers >= 32'd1) &&
                  (cfg_num_layers <= 32'(max_layer_size));

  // row_ready is the only output not taken from a flop: it reports that the
  // row offered this very cycle is being consumed, so upstream can advance
  // its data on the same edge the row counter advances.
  assign row_ready = (state == S_ROW_FEED) && row_valid && !abort;

  // Next-state logic. Layer/row indices are zeroed whenever the sequencer
  // falls back to IDLE so that the idle outputs read as all zeros.
  always_comb begin
    state_n      = state;
    num_layers_n = num_layers;
    layer_n      = current_input_layer;
    row_n        = current_input_row;
    upd_cnt_n    = upd_cnt;
    idle_cnt_n   = idle_cnt;
    err_n        = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            num_layers_n = cfg_num_layers;
            layer_n      = cfg_num_layers - 32'd1;
            row_n        = 32'd0;
            state_n      = S_LAYER_START;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      S_LAYER_START: begin
        row_n   = 32'd0;
        state_n = S_ROW_FEED;
      end

      S_ROW_FEED: begin
        if (row_valid) begin
          if (current_input_row == 32'(size - 1)) begin
            upd_cnt_n  = '0;
            idle_cnt_n = '0;
            state_n    = S_DRAIN;
          end else begin
            row_n = current_input_row + 32'd1;
          end
        end
      end

      // The layer finishes on the cycle the size-th update arrives, and the
      // timeout fires on the drain_timeout-th consecutive empty cycle.
      S_DRAIN: begin
        if (is_update_weight) begin
          idle_cnt_n = '0;
          if (upd_inc == cnt_w'(size)) begin
            upd_cnt_n = '0;
            row_n     = 32'd0;
            if (current_input_layer == 32'd0) begin
              state_n = S_DONE;
            end else begin
              layer_n = current_input_layer - 32'd1;
              state_n = S_LAYER_START;
            end
          end else begin
            upd_cnt_n = upd_inc;
          end
        end else if (idle_inc == cnt_w'(drain_timeout)) begin
          err_n      = 1'b1;
          idle_cnt_n = '0;
          upd_cnt_n  = '0;
          layer_n    = 32'd0;
          row_n      = 32'd0;
          state_n    = S_IDLE;
        end else begin
          idle_cnt_n = idle_inc;
        end
      end

      S_DONE: begin
        layer_n = 32'd0;
        row_n   = 32'd0;
        state_n = S_IDLE;
      end

      default: begin
        layer_n = 32'd0;
        row_n   = 32'd0;
        state_n = S_IDLE;
      end
    endcase

    // Abort wins over every transition above and is not an error.
    if (abort) begin
      state_n    = S_IDLE;
      layer_n    = 32'd0;
      row_n      = 32'd0;
      upd_cnt_n  = '0;
      idle_cnt_n = '0;
      err_n      = 1'b0;
    end
  end

  assign active_n = (state_n == S_LAYER_START) ||
                    (state_n == S_ROW_FEED) ||
                    (state_n == S_DRAIN);

  // State, counters and the registered outputs, all decoded from next-state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      num_layers          <= 32'd0;
      upd_cnt             <= '0;
      idle_cnt            <= '0;
      current_input_layer <= 32'd0;
      current_input_row   <= 32'd0;
      is_last_layer       <= 1'b0;
      start_new_layer     <= 1'b0;
      read_update_data    <= 1'b0;
      active_train        <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      err                 <= 1'b0;
    end else begin
      state               <= state_n;
      num_layers          <= num_layers_n;
      upd_cnt             <= upd_cnt_n;
      idle_cnt            <= idle_cnt_n;
      current_input_layer <= layer_n;
      current_input_row   <= row_n;
      is_last_layer       <= active_n && (layer_n == num_layers_n - 32'd1);
      start_new_layer     <= (state_n == S_LAYER_START);
      read_update_data    <= (state_n == S_DRAIN);
      active_train        <= active_n;
      busy                <= (state_n != S_IDLE);
      done                <= (state_n == S_DONE);
      err                 <= err_n;
    end
  end

endmodule

// File: tb/tb_backprop_sequencer.sv
// ---------------------------------------------------------------------------
// tb_backprop_sequencer
//
// Directed testbench for backprop_sequencer (max_layer_size=4, size=3,
// drain_timeout=16). Inputs are driven on the falling edge and outputs are
// sampled on the falling edge, half a cycle after the active edge. The
// single-bit outputs are grouped into one flag vector, ordered
//   {start_new_layer, read_update_data, active_train, busy,
//    done, err, is_last_layer, row_ready}
// ---------------------------------------------------------------------------
module tb_backprop_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] cfg_num_layers;
  logic        row_valid;
  logic        is_update_weight;
  logic        row_ready;
  logic [31:0] current_input_layer;
  logic [31:0] current_input_row;
  logic        is_last_layer;
  logic        start_new_layer;
  logic        read_update_data;
  logic        active_train;
  logic        busy;
  logic        done;
  logic        err;

  logic [7:0]  flags;
  int          checks   = 0;
  int          failures = 0;

  assign flags = {start_new_layer, read_update_data, active_train, busy,
                  done, err, is_last_layer, row_ready};

  backprop_sequencer #(
    .max_layer_size(4),
    .data_size     (16),
    .size          (3),
    .drain_timeout (16)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .abort              (abort),
    .cfg_num_layers     (cfg_num_layers),
    .row_valid          (row_valid),
    .is_update_weight   (is_update_weight),
    .row_ready          (row_ready),
    .current_input_layer(current_input_layer),
    .current_input_row  (current_input_row),
    .is_last_layer      (is_last_layer),
    .start_new_layer    (start_new_layer),
    .read_update_data   (read_update_data),
    .active_train       (active_train),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  always #5 clk = ~clk;

  // Hard stop in case something in the bench itself stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    start            = 1'b0;
    abort            = 1'b0;
    cfg_num_layers   = 32'd0;
    row_valid        = 1'b0;
    is_update_weight = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (flags !== 8'b0000_0000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b expected=%b", flags, 8'b0000_0000);
    end
    checks++;
    if (current_input_layer !== 32'd0 || current_input_row !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_indices got layer=%0d row=%0d expected 0/0",
               current_input_layer, current_input_row);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (flags !== 8'b0000_0000) begin
      failures++;
      $display("[TB] FAIL reset_idle got=%b expected=%b", flags, 8'b0000_0000);
    end
  endtask

  // Complete pass of nl layers with rows always valid and updates always
  // offered, so every layer is 1 + 3 + 3 cycles.
  task automatic test_full_pass(input int nl);
    logic [7:0] exp;
    logic       last;
    row_valid        = 1'b1;
    is_update_weight = 1'b1;
    cfg_num_layers   = 32'(nl);
    start            = 1'b1;
    step();
    start = 1'b0;
    for (int l = nl - 1; l >= 0; l--) begin
      last = (l == nl - 1);
      exp  = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, last, 1'b0};
      checks++;
      if (flags !== exp || current_input_layer !== 32'(l) || current_input_row !== 32'd0) begin
        failures++;
        $display("[TB] FAIL pass%0d_layer_start l=%0d got flags=%b layer=%0d row=%0d expected flags=%b layer=%0d row=0",
                 nl, l, flags, current_input_layer, current_input_row, exp, l);
      end
      step();
      for (int r = 0; r < 3; r++) begin
        exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, last, 1'b1};
        checks++;
        if (flags !== exp || current_input_layer !== 32'(l) || current_input_row !== 32'(r)) begin
          failures++;
          $display("[TB] FAIL pass%0d_row_feed l=%0d r=%0d got flags=%b layer=%0d row=%0d expected flags=%b",
                   nl, l, r, flags, current_input_layer, current_input_row, exp);
        end
        step();
      end
      for (int d = 0; d < 3; d++) begin
        exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, last, 1'b0};
        checks++;
        if (flags !== exp || current_input_layer !== 32'(l)) begin
          failures++;
          $display("[TB] FAIL pass%0d_drain l=%0d d=%0d got flags=%b layer=%0d expected flags=%b layer=%0d",
                   nl, l, d, flags, current_input_layer, exp, l);
        end
        step();
      end
    end
    checks++;
    if (flags !== 8'b0001_1000 || current_input_layer !== 32'd0) begin
      failures++;
      $display("[TB] FAIL pass%0d_done got flags=%b layer=%0d expected flags=%b layer=0",
               nl, flags, current_input_layer, 8'b0001_1000);
    end
    step();
    checks++;
    if (flags !== 8'b0000_0000 || current_input_layer !== 32'd0 || current_input_row !== 32'd0) begin
      failures++;
      $display("[TB] FAIL pass%0d_idle got flags=%b layer=%0d row=%0d expected all zero",
               nl, flags, current_input_layer, current_input_row);
    end
  endtask

  task automatic test_bad_cfg();
    logic [31:0] bad [2];
    bad[0] = 32'd0;
    bad[1] = 32'd5;
    for (int i = 0; i < 2; i++) begin
      cfg_num_layers = bad[i];
      start          = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (flags !== 8'b0000_0100 || current_input_layer !== 32'd0) begin
        failures++;
        $display("[TB] FAIL bad_cfg_err cfg=%0d got flags=%b expected=%b",
                 bad[i], flags, 8'b0000_0100);
      end
      step();
      checks++;
      if (flags !== 8'b0000_0000) begin
        failures++;
        $display("[TB] FAIL bad_cfg_after cfg=%0d got flags=%b expected=%b",
                 bad[i], flags, 8'b0000_0000);
      end
    end
  endtask

  task automatic test_row_stall();
    row_valid        = 1'b1;
    is_update_weight = 1'b1;
    cfg_num_layers   = 32'd1;
    start            = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (current_input_row !== 32'd1 || flags !== 8'b0011_0011) begin
      failures++;
      $display("[TB] FAIL stall_row1 got row=%0d flags=%b expected row=1 flags=%b",
               current_input_row, flags, 8'b0011_0011);
    end
    row_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (current_input_row !== 32'd1 || flags !== 8'b0011_0010) begin
        failures++;
        $display("[TB] FAIL stall_hold%0d got row=%0d flags=%b expected row=1 flags=%b",
                 i, current_input_row, flags, 8'b0011_0010);
      end
    end
    row_valid = 1'b1;
    #1;
    checks++;
    if (row_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_ready_back got=%b expected=1", row_ready);
    end
    step();
    checks++;
    if (current_input_row !== 32'd2 || flags !== 8'b0011_0011) begin
      failures++;
      $display("[TB] FAIL stall_resume got row=%0d flags=%b expected row=2 flags=%b",
               current_input_row, flags, 8'b0011_0011);
    end
    repeat (4) step();
    checks++;
    if (flags !== 8'b0001_1000) begin
      failures++;
      $display("[TB] FAIL stall_done got flags=%b expected=%b", flags, 8'b0001_1000);
    end
    step();
  endtask

  task automatic test_drain_timeout();
    row_valid        = 1'b1;
    is_update_weight = 1'b0;
    cfg_num_layers   = 32'd1;
    start            = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (flags !== 8'b0111_0010) begin
        failures++;
        $display("[TB] FAIL timeout_drain cycle=%0d got flags=%b expected=%b",
                 k, flags, 8'b0111_0010);
      end
      step();
    end
    checks++;
    if (flags !== 8'b0000_0100 || current_input_layer !== 32'd0 || current_input_row !== 32'd0) begin
      failures++;
      $display("[TB] FAIL timeout_err got flags=%b layer=%0d row=%0d expected flags=%b",
               flags, current_input_layer, current_input_row, 8'b0000_0100);
    end
    step();
    checks++;
    if (flags !== 8'b0000_0000) begin
      failures++;
      $display("[TB] FAIL timeout_idle got flags=%b expected=%b", flags, 8'b0000_0000);
    end
  endtask

  task automatic test_abort();
    row_valid        = 1'b1;
    is_update_weight = 1'b1;
    cfg_num_layers   = 32'd3;
    start            = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    checks++;
    if (flags !== 8'b1011_0000 || current_input_layer !== 32'd1) begin
      failures++;
      $display("[TB] FAIL abort_layer1_start got flags=%b layer=%0d expected flags=%b layer=1",
               flags, current_input_layer, 8'b1011_0000);
    end
    step();
    // A start while busy must be ignored.
    cfg_num_layers = 32'd1;
    start          = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (current_input_layer !== 32'd1 || current_input_row !== 32'd1) begin
      failures++;
      $display("[TB] FAIL busy_start_ignored got layer=%0d row=%0d expected 1/1",
               current_input_layer, current_input_row);
    end
    abort = 1'b1;
    #1;
    checks++;
    if (row_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_row_ready got=%b expected=0", row_ready);
    end
    step();
    abort = 1'b0;
    checks++;
    if (flags !== 8'b0000_0000 || current_input_layer !== 32'd0 || current_input_row !== 32'd0) begin
      failures++;
      $display("[TB] FAIL abort_idle got flags=%b layer=%0d row=%0d expected all zero",
               flags, current_input_layer, current_input_row);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (flags !== 8'b0000_0000) begin
        failures++;
        $display("[TB] FAIL abort_no_done cycle=%0d got flags=%b expected=%b",
                 i, flags, 8'b0000_0000);
      end
    end
    cfg_num_layers = 32'd3;
    start          = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (flags !== 8'b1011_0010 || current_input_layer !== 32'd2) begin
      failures++;
      $display("[TB] FAIL abort_restart got flags=%b layer=%0d expected flags=%b layer=2",
               flags, current_input_layer, 8'b1011_0010);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    row_valid        = 1'b1;
    is_update_weight = 1'b1;
    cfg_num_layers   = 32'd1;
    start            = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    checks++;
    if (flags !== 8'b0001_1000) begin
      failures++;
      $display("[TB] FAIL b2b_done got flags=%b expected=%b", flags, 8'b0001_1000);
    end
    // start offered during DONE is not taken; it is taken once IDLE.
    cfg_num_layers = 32'd2;
    start          = 1'b1;
    step();
    checks++;
    if (flags !== 8'b0000_0000) begin
      failures++;
      $display("[TB] FAIL b2b_done_start_ignored got flags=%b expected=%b",
               flags, 8'b0000_0000);
    end
    step();
    start = 1'b0;
    checks++;
    if (flags !== 8'b1011_0010 || current_input_layer !== 32'd1) begin
      failures++;
      $display("[TB] FAIL b2b_restart got flags=%b layer=%0d expected flags=%b layer=1",
               flags, current_input_layer, 8'b1011_0010);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    row_valid        = 1'b1;
    is_update_weight = 1'b0;
    cfg_num_layers   = 32'd2;
    start            = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    checks++;
    if (flags !== 8'b0111_0010 || current_input_layer !== 32'd1) begin
      failures++;
      $display("[TB] FAIL async_pre_drain got flags=%b layer=%0d expected flags=%b layer=1",
               flags, current_input_layer, 8'b0111_0010);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (flags !== 8'b0000_0000 || current_input_layer !== 32'd0 || current_input_row !== 32'd0) begin
      failures++;
      $display("[TB] FAIL async_reset got flags=%b layer=%0d row=%0d expected all zero",
               flags, current_input_layer, current_input_row);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_full_pass(1);
  endtask

  initial begin
    test_reset();
    test_full_pass(3);
    test_bad_cfg();
    test_row_stall();
    test_drain_timeout();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
